// File: rtl/byte2word_fifo.sv
// byte2word_fifo: packs a byte stream little-endian into 32-bit words and queues them in a FWFT FIFO
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   in_data/valid/ready   byte input handshake
//   out_data/valid/ready  word output handshake, head word read asynchronously
//   word_count        complete words stored (0..DEPTH)
//   byte_lane         bytes held in the partial-word assembler (0..3)
//   flush             commit a zero-padded partial word; only when BYTE2WORD_FLUSH_EN is defined
module byte2word_fifo #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic [1:0]            byte_lane
`ifdef BYTE2WORD_FLUSH_EN
   ,input  logic                  flush
`endif
);
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
    logic [31:0]           mem [1<<ADDR_WIDTH];
    logic [23:0]           asm_q, asm_d;
    logic [ADDR_WIDTH-1:0] wptr, rptr;
    logic                  full, accept, flush_on, flush_push, push, pop;
    logic [31:0]           wdata;
`ifdef BYTE2WORD_FLUSH_EN
    assign flush_on = flush;
`else
    assign flush_on = 1'b0;
`endif
    always_comb begin
        full       = word_count == DEPTH;
        in_ready   = !full && !rst && !flush_on;
        out_valid  = (word_count != '0) && !rst;
        out_data   = mem[rptr];
        accept     = in_valid && in_ready;
        // upper lanes of asm_q are already zero, so a flushed word comes out zero-padded
        flush_push = flush_on && (byte_lane != 2'd0) && !full && !rst;
        push       = (accept && byte_lane == 2'd3) || flush_push;
        pop        = out_valid && out_ready;
        asm_d      = {byte_lane == 2'd2 ? in_data : asm_q[23:16],
                      byte_lane == 2'd1 ? in_data : asm_q[15:8],
                      byte_lane == 2'd0 ? in_data : asm_q[7:0]};
        wdata      = flush_push ? {8'h00, asm_q} : {in_data, asm_q};
    end
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            word_count <= '0;
            wptr       <= '0;
            rptr       <= '0;
            byte_lane  <= '0;
            asm_q      <= '0;
        end else begin
            if (accept) begin
                byte_lane <= byte_lane + 2'd1;
                asm_q     <= byte_lane == 2'd3 ? 24'h0 : asm_d;
            end else if (flush_push) begin
                byte_lane <= '0;
                asm_q     <= '0;
            end
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            word_count <= (push && !pop) ? word_count + 1'b1 :
                          (!push && pop) ? word_count - 1'b1 : word_count;
        end
    end
endmodule
